frame_writer: RTL

//  Producer end of the frame memory that frame_reader consumes.
//  - Accepts a stream of 8-bit point coordinates ({row[3:0], col[3:0]} on the 16x16 matrix).
//  - Accumulates the points of one frame into an internal 16x16 bitmap.
//  - On end-of-frame, flushes the bitmap as 16 row words into frame RAM at frame slot frame_num.
//  - Then advances frame_num for the next frame.

---
 rtl/frame_writer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/frame_writer.sv
// ---------------------------------------------------------------------------
// frame_writer
//   Producer side of the frame memory read by frame_reader. Point beats
//   ({row[3:0], col[3:0]} on a 16x16 matrix) are collected into a bitmap.
//   When the last beat of a frame arrives, the bitmap is flushed as 16 row
//   words to frame RAM at slot frame_num, then frame_num advances.
//
// Ports
//   clock         in   single clock, all state on posedge
//   reset         in   asynchronous, active-high
//   point_valid   in   producer presents a beat
//   point_ready   out  writer accepts a beat (combinational from state)
//   point_enable  in   beat carries a point in point_coord
//   point_coord   in   [7:4] row, [3:0] col
//   point_last    in   final beat of the current frame
//   mem_we        out  frame RAM write strobe (registered)
//   mem_addr      out  {frame_num, row} (registered)
//   mem_data      out  row word, bit c = column c lit (registered)
//   frame_num     out  slot the current/flushing frame is written to
//   frame_done    out  one-cycle pulse once all 16 rows are written
//   dbg_state_o   out  current FSM state, for observation only
//
// Handshake: a beat transfers on a rising clock edge where point_valid and
// point_ready are both 1. The producer must hold the beat stable until then.
//
// Timing (edge T = edge that takes the last beat):
//   edge T      : row 0 write registered (the last beat's point is merged in)
//   edges T+1.. : rows 1..15 registered, one per edge
//   edge T+16   : frame_done registered, frame_num advances, back to COLLECT
//   edge T+17   : earliest edge that can take the next beat
// ---------------------------------------------------------------------------
module frame_writer #(
    parameter int FRAME_W = 8,
    parameter int ADDR_W  = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               point_valid,
    output logic               point_ready,
    input  logic               point_enable,
    input  logic [7:0]         point_coord,
    input  logic               point_last,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [15:0]        mem_data,
    output logic [FRAME_W-1:0] frame_num,
    output logic               frame_done,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FLUSH   = 2'd1,
        FINISH  = 2'd2
    } state_t;

    state_t             state_q;
    logic [15:0]        bitmap_q [16];
    logic [3:0]         row_idx_q;
    logic [FRAME_W-1:0] frame_num_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [15:0]        mem_data_q;
    logic               frame_done_q;

    logic               accept;
    logic [15:0]        point_mask;
    logic [15:0]        row0_d;

    assign point_ready = (state_q == COLLECT);
    assign accept      = point_valid && point_ready;
    assign point_mask  = 16'h0001 << point_coord[3:0];

    // Row 0 is written on the same edge that takes the last beat, so it must
    // already include that beat's point if it lands in row 0.
    always_comb begin
        row0_d = bitmap_q[0];
        if (point_enable && (point_coord[7:4] == 4'd0)) begin
            row0_d = bitmap_q[0] | point_mask;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            row_idx_q    <= 4'd0;
            frame_num_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= 16'h0000;
            frame_done_q <= 1'b0;
            for (int r = 0; r < 16; r++) begin
                bitmap_q[r] <= 16'h0000;
            end
        end else begin
            case (state_q)
                COLLECT: begin
                    mem_we_q     <= 1'b0;
                    frame_done_q <= 1'b0;
                    if (accept) begin
                        if (point_enable) begin
                            bitmap_q[point_coord[7:4]][point_coord[3:0]] <= 1'b1;
                        end
                        if (point_last) begin
                            // Later assignment wins: row 0 is cleared even if
                            // the last point set a bit in it, since row0_d
                            // already carries that bit to the RAM.
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {frame_num_q, 4'd0};
                            mem_data_q  <= row0_d;
                            bitmap_q[0] <= 16'h0000;
                            row_idx_q   <= 4'd1;
                            state_q     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    mem_we_q            <= 1'b1;
                    mem_addr_q          <= {frame_num_q, row_idx_q};
                    mem_data_q          <= bitmap_q[row_idx_q];
                    bitmap_q[row_idx_q] <= 16'h0000;
                    row_idx_q           <= row_idx_q + 4'd1;
                    if (row_idx_q == 4'd15) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    // Row 15 is on the bus now; wrap to the next slot.
                    mem_we_q     <= 1'b0;
                    frame_done_q <= 1'b1;
                    frame_num_q  <= frame_num_q + 1'b1;
                    row_idx_q    <= 4'd0;
                    state_q      <= COLLECT;
                end
                default: begin
                    mem_we_q     <= 1'b0;
                    frame_done_q <= 1'b0;
                    state_q      <= COLLECT;
                end
            endcase
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign frame_num   = frame_num_q;
    assign frame_done  = frame_done_q;
    assign dbg_state_o = state_q;

endmodule
